// File: rtl/sdram_capture_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_capture_writer
//  Description : Streams 16-bit ADC samples into a ring buffer in SDRAM over
//                an Avalon-MM write master.
//
//                Samples enter a FIFO. A single output register feeds the
//                Avalon bus. When a transfer completes, the FIFO head loads
//                into that register on the same edge, so consecutive writes
//                have no idle cycle between them. The write address advances
//                through RING_WORDS words starting at ADDR_BASE and wraps
//                back to the start of the ring.
//
//  Control     : IDLE --start--> RUN --stop--> DRAIN --(FIFO and output
//                register empty)--> IDLE, with a one-cycle pulse on done.
//
//  Ports       : M100CLK, reset      clock, synchronous active-high reset
//                start, stop         one-cycle capture control pulses
//                sample_valid/data   sample input; used only in RUN
//                Write_*             Avalon-MM write master
//                busy, done          status
//                overflow, wrapped   sticky flags, cleared on start
//                words_written       completed transfers since start
//                drop_count          dropped samples (saturating)
//
//  Option      : define CAPTURE_DROP_COUNT_EN to build the drop counter.
//                When it is not defined, drop_count is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_capture_writer #(
    parameter logic [24:0] ADDR_BASE  = 25'd0,
    parameter int          RING_WORDS = 2048,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        M100CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        Write_WaitRequest,
    output logic        Write_ChipEnable,
    output logic [24:0] Write_Address,
    output logic [1:0]  Write_ByteEnable,
    output logic [15:0] Write_WriteData,
    output logic        Write_Write,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        wrapped,
    output logic [24:0] words_written,
    output logic [15:0] drop_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OFF_W = $clog2(RING_WORDS);
    localparam logic [c_OFF_W-1:0] c_OFF_LAST = c_OFF_W'(RING_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [15:0]          r_mem [FIFO_DEPTH];
    // Each pointer carries one extra wrap bit so that full and empty
    // can be told apart.
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;
    logic                 r_out_valid;
    logic [15:0]          r_out_data;
    logic [c_OFF_W-1:0]   r_offset;
    logic                 r_done;
    logic                 r_overflow;
    logic                 r_wrapped;
    logic [24:0]          r_words;

    logic w_empty;
    logic w_full;
    logic w_xfer;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_drop;
    logic w_start;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_xfer     = r_out_valid & ~Write_WaitRequest;
    // The output register can take the FIFO head when it is empty now,
    // or when its word completes on this edge.
    assign w_pop      = ~w_empty & (~r_out_valid | ~Write_WaitRequest);
    assign w_push_req = (r_state == ST_RUN) & sample_valid;
    // A full FIFO still accepts a sample if it pops on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;
    assign w_start    = (r_state == ST_IDLE) & start;

    // Sample storage has no reset. Its contents are meaningful only
    // between the read and write pointers.
    always_ff @(posedge M100CLK) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= sample_data;
        end
    end

    always_ff @(posedge M100CLK) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'd0;
            r_offset    <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_wrapped   <= 1'b0;
            r_words     <= 25'd0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // When start and stop arrive together, start wins.
                    if (stop && !start) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !r_out_valid) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Output register.
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[r_rd_ptr[c_PTR_W-1:0]];
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            // FIFO pointers. Start only happens in IDLE, where there are
            // no pushes, so clearing the pointers cannot lose a sample.
            if (w_start) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
                end
            end

            // Ring address, transfer count and sticky flags.
            if (w_start) begin
                r_offset   <= '0;
                r_words    <= 25'd0;
                r_overflow <= 1'b0;
                r_wrapped  <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_words <= r_words + 25'd1;
                    if (r_offset == c_OFF_LAST) begin
                        r_offset  <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_offset <= r_offset + c_OFF_W'(1);
                    end
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef CAPTURE_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge M100CLK) begin
        if (reset) begin
            r_drop_count <= 16'd0;
        end else if (w_start) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'd0;
`endif

    assign Write_ChipEnable = 1'b1;
    assign Write_ByteEnable = 2'b11;
    assign Write_Address    = ADDR_BASE + 25'(r_offset);
    assign Write_WriteData  = r_out_data;
    assign Write_Write      = r_out_valid;
    assign busy             = (r_state != ST_IDLE);
    assign done             = r_done;
    assign overflow         = r_overflow;
    assign wrapped          = r_wrapped;
    assign words_written    = r_words;

endmodule
`default_nettype wire

// File: tb/tb_sdram_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_capture_writer
//  Description : Self-checking bench for sdram_capture_writer. Two instances
//                receive the same stimulus and differ only in their ring
//                parameters. A queue-based reference model predicts every
//                output on every cycle. Directed sequences and a vector
//                table cover the corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_capture_writer;

    localparam logic [24:0] BASE_A = 25'h0000100;
    localparam int          RING_A = 8;
    localparam int          RING_B = 4;
    localparam int          FD     = 16;

    logic        clk = 1'b0;
    logic        rst, start, stop, sv, wr;
    logic [15:0] sd;

    logic        a_ce, a_w, a_busy, a_done, a_ovf, a_wrap;
    logic [24:0] a_addr, a_ww;
    logic [1:0]  a_be;
    logic [15:0] a_wd, a_dc;
    logic        b_ce, b_w, b_busy, b_done, b_ovf, b_wrap;
    logic [24:0] b_addr, b_ww;
    logic [1:0]  b_be;
    logic [15:0] b_wd, b_dc;

    sdram_capture_writer #(.ADDR_BASE(BASE_A), .RING_WORDS(RING_A), .FIFO_DEPTH(FD)) dut_a (
        .M100CLK(clk), .reset(rst), .start(start), .stop(stop),
        .sample_valid(sv), .sample_data(sd), .Write_WaitRequest(wr),
        .Write_ChipEnable(a_ce), .Write_Address(a_addr), .Write_ByteEnable(a_be),
        .Write_WriteData(a_wd), .Write_Write(a_w), .busy(a_busy), .done(a_done),
        .overflow(a_ovf), .wrapped(a_wrap), .words_written(a_ww), .drop_count(a_dc)
    );

    sdram_capture_writer #(.ADDR_BASE(25'd0), .RING_WORDS(RING_B), .FIFO_DEPTH(FD)) dut_b (
        .M100CLK(clk), .reset(rst), .start(start), .stop(stop),
        .sample_valid(sv), .sample_data(sd), .Write_WaitRequest(wr),
        .Write_ChipEnable(b_ce), .Write_Address(b_addr), .Write_ByteEnable(b_be),
        .Write_WriteData(b_wd), .Write_Write(b_w), .busy(b_busy), .done(b_done),
        .overflow(b_ovf), .wrapped(b_wrap), .words_written(b_ww), .drop_count(b_dc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Captures: 0 idle, 1 running, 2 draining. The buffered samples are a
    // plain queue, the bus word is one slot, and every address and flag
    // follows from the number of completed writes since start.
    int           m_st = 0;
    logic [15:0]  m_fifo[$];
    bit           m_out_v = 0;
    logic [15:0]  m_out_d = 16'd0;
    int           m_total = 0;
    bit           m_ovf = 0;
    int           m_drops = 0;
    bit           m_done = 0;

    typedef struct { logic [24:0] a; logic [15:0] d; } wr_t;
    wr_t log_a[$];
    wr_t log_b[$];

    function automatic logic [15:0] exp_dc();
`ifdef CAPTURE_DROP_COUNT_EN
        return 16'(m_drops);
`else
        return 16'd0;
`endif
    endfunction

    task automatic step();
        bit xfer, pop_ok, push_req, acc, drain_done;
        // Record the writes the DUTs complete on the coming edge.
        if (a_w && !wr) log_a.push_back('{a_addr, a_wd});
        if (b_w && !wr) log_b.push_back('{b_addr, b_wd});
        if (rst) begin
            m_st = 0; m_fifo.delete(); m_out_v = 0; m_out_d = 16'd0;
            m_total = 0; m_ovf = 0; m_drops = 0; m_done = 0;
        end else begin
            xfer       = m_out_v && !wr;
            pop_ok     = (m_fifo.size() > 0) && (!m_out_v || !wr);
            push_req   = (m_st == 1) && sv;
            acc        = push_req && ((m_fifo.size() < FD) || pop_ok);
            drain_done = (m_st == 2) && (m_fifo.size() == 0) && !m_out_v;
            m_done     = drain_done;
            if (xfer) m_total++;
            if (pop_ok) begin
                m_out_d = m_fifo.pop_front();
                m_out_v = 1;
            end else if (xfer) begin
                m_out_v = 0;
            end
            if (acc) m_fifo.push_back(sd);
            else if (push_req) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
            case (m_st)
                0: if (start) begin
                       m_st = 1; m_fifo.delete(); m_ovf = 0; m_total = 0; m_drops = 0;
                   end
                1: if (stop && !start) m_st = 2;
                2: if (drain_done) m_st = 0;
                default: m_st = 0;
            endcase
        end
        @(posedge clk);
        #1;
        chk("write_a", a_w, m_out_v);
        chk("write_b", b_w, m_out_v);
        if (m_out_v) begin
            chk("wdata_a", a_wd, m_out_d);
            chk("wdata_b", b_wd, m_out_d);
        end
        chk("addr_a", a_addr, BASE_A + 25'(m_total % RING_A));
        chk("addr_b", b_addr, 25'(m_total % RING_B));
        chk("busy_a", a_busy, m_st != 0);
        chk("done_a", a_done, m_done);
        chk("done_b", b_done, m_done);
        chk("ovf_a", a_ovf, m_ovf);
        chk("wrap_a", a_wrap, m_total >= RING_A);
        chk("wrap_b", b_wrap, m_total >= RING_B);
        chk("ww_a", a_ww, 25'(m_total));
        chk("dc_a", a_dc, exp_dc());
        chk("ce_be_a", {a_ce, a_be}, 3'b111);
    endtask

    task automatic idle_in();
        start = 0; stop = 0; sv = 0; wr = 0; sd = 16'd0;
    endtask

    task automatic do_reset();
        idle_in(); rst = 1; step(); rst = 0;
    endtask

    task automatic begin_run();
        start = 1; step(); start = 0;
        log_a.delete(); log_b.delete();
    endtask

    task automatic finish_run(input string tag);
        int n = 0;
        sv = 0; stop = 1; step(); stop = 0; wr = 0;
        while ((a_busy || m_st != 0) && n < 300) begin step(); n++; end
        chk({tag, "_drain_timeout"}, n < 300, 1);
    endtask

    // -------------- vector table --------------
    typedef struct {
        logic start, stop, sv; logic [15:0] d; logic wr;
        logic e_w; logic [15:0] e_d; int e_off; logic e_busy, e_done; int e_ww;
    } vec_t;
    vec_t vt[8];

    initial begin
        int done_cnt, after;
        logic [24:0] frz_a;
        logic [15:0] frz_d;

        vt[0] = '{1,0,0,16'h0000,0, 0,16'h0000,0,1,0,0};
        vt[1] = '{0,0,1,16'h00A1,0, 0,16'h0000,0,1,0,0};
        vt[2] = '{0,0,1,16'h00A2,0, 1,16'h00A1,0,1,0,0};
        vt[3] = '{0,0,0,16'h0000,1, 1,16'h00A1,0,1,0,0};
        vt[4] = '{0,1,0,16'h0000,0, 1,16'h00A2,1,1,0,1};
        vt[5] = '{0,0,1,16'h00FF,0, 0,16'h0000,2,1,0,2};
        vt[6] = '{0,0,0,16'h0000,0, 0,16'h0000,2,0,1,2};
        vt[7] = '{0,0,0,16'h0000,0, 0,16'h0000,2,0,0,2};

        // Reset state
        idle_in(); rst = 1; step(); step(); rst = 0;
        chk("rst_write", a_w, 0);
        chk("rst_addr", a_addr, BASE_A);
        chk("rst_wdata", a_wd, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_flags", {a_ovf, a_wrap}, 0);
        chk("rst_ww", a_ww, 0);
        chk("rst_dc", a_dc, 0);

        // Table-driven sequence from IDLE
        for (int i = 0; i < 8; i++) begin
            start = vt[i].start; stop = vt[i].stop; sv = vt[i].sv;
            sd = vt[i].d; wr = vt[i].wr;
            step();
            chk($sformatf("vec%0d_write", i), a_w, vt[i].e_w);
            if (vt[i].e_w) chk($sformatf("vec%0d_data", i), a_wd, vt[i].e_d);
            chk($sformatf("vec%0d_addr", i), a_addr, BASE_A + 25'(vt[i].e_off));
            chk($sformatf("vec%0d_busy", i), a_busy, vt[i].e_busy);
            chk($sformatf("vec%0d_done", i), a_done, vt[i].e_done);
            chk($sformatf("vec%0d_ww", i), a_ww, 25'(vt[i].e_ww));
        end
        idle_in();

        // Eight samples, no stall
        do_reset(); begin_run();
        for (int i = 1; i <= 8; i++) begin sv = 1; sd = 16'(i); step(); end
        finish_run("seq8");
        chk("seq8_count", log_a.size(), 8);
        for (int i = 0; i < log_a.size() && i < 8; i++) begin
            chk("seq8_addr", log_a[i].a, BASE_A + 25'(i));
            chk("seq8_data", log_a[i].d, 16'(i + 1));
        end
        chk("seq8_ww", a_ww, 8);

        // Ten-cycle stall in the middle of a stream
        do_reset(); begin_run();
        for (int c = 0; c < 25; c++) begin
            sv = (c < 12); sd = 16'h2400 + 16'(c); wr = (c >= 4 && c < 14);
            step();
            if (c == 4) begin frz_a = a_addr; frz_d = a_wd; end
            if (c > 4 && c < 14) begin
                chk("stall_write", a_w, 1);
                chk("stall_addr", a_addr, frz_a);
                chk("stall_data", a_wd, frz_d);
            end
        end
        finish_run("stall");
        chk("stall_count", log_a.size(), 12);
        for (int i = 0; i < log_a.size() && i < 12; i++) begin
            chk("stall_order_d", log_a[i].d, 16'h2400 + 16'(i));
            chk("stall_order_a", log_a[i].a, BASE_A + 25'(i % RING_A));
        end
        chk("stall_ovf", a_ovf, 0);

        // Overflow while the bus is stalled
        do_reset(); begin_run();
        wr = 1;
        for (int i = 0; i < 20; i++) begin sv = 1; sd = 16'h3300 + 16'(i); step(); end
        sv = 0; step();
        chk("ovf_flag", a_ovf, 1);
`ifdef CAPTURE_DROP_COUNT_EN
        chk("ovf_drops", a_dc, 3);
`else
        chk("ovf_drops", a_dc, 0);
`endif
        wr = 0;
        finish_run("ovf");
        chk("ovf_count", log_a.size(), 17);
        for (int i = 0; i < log_a.size() && i < 17; i++)
            chk("ovf_order", log_a[i].d, 16'h3300 + 16'(i));

        // Ring wrap on the RING_WORDS=4 instance
        do_reset(); begin_run();
        for (int i = 0; i < 6; i++) begin sv = 1; sd = 16'h4400 + 16'(i); step(); end
        finish_run("wrap");
        chk("wrap_count", log_b.size(), 6);
        for (int i = 0; i < log_b.size() && i < 6; i++)
            chk("wrap_addr", log_b[i].a, 25'(i % 4));
        chk("wrap_flag_b", b_wrap, 1);
        chk("wrap_flag_a", a_wrap, 0);

        // Stop with five words buffered, and samples arriving during DRAIN
        do_reset(); begin_run();
        wr = 1;
        for (int i = 0; i < 5; i++) begin sv = 1; sd = 16'h5500 + 16'(i); step(); end
        sv = 0; stop = 1; step(); stop = 0; wr = 0;
        done_cnt = 0; after = 0;
        for (int c = 0; c < 60 && after < 3; c++) begin
            sv = 1; sd = 16'hBAD0 + 16'(c);
            step();
            if (a_done) done_cnt++;
            if (done_cnt > 0) after++;
        end
        sv = 0;
        chk("drain_done_pulses", done_cnt, 1);
        chk("drain_busy", a_busy, 0);
        chk("drain_count", log_a.size(), 5);
        for (int i = 0; i < log_a.size() && i < 5; i++)
            chk("drain_data", log_a[i].d, 16'h5500 + 16'(i));
        chk("drain_ovf", a_ovf, 0);

        // Reset during a stalled write
        do_reset(); begin_run();
        wr = 1; sv = 1; sd = 16'h6600; step(); sv = 0; step(); step();
        chk("rstall_pre_write", a_w, 1);
        rst = 1; step(); rst = 0;
        chk("rstall_write", a_w, 0);
        chk("rstall_addr", a_addr, BASE_A);
        wr = 0; log_a.delete(); step(); step();
        chk("rstall_discard", log_a.size(), 0);

        // Randomised stimulus against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(999, 0) < 2);
            start = ($urandom_range(99, 0) < 3);
            stop  = ($urandom_range(99, 0) < 2);
            sv    = ($urandom_range(99, 0) < 60);
            wr    = ($urandom_range(99, 0) < 35);
            sd    = 16'($urandom);
            step();
        end
        rst = 0; start = 0;
        finish_run("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_capture_writer.md
SDRAM_CAPTURE_WRITER -- requirements
Module: sdram_capture_writer

Interface
REQ-001 Parameter ADDR_BASE, default 25'd0, SHALL set the first SDRAM word address of the capture ring.
REQ-002 Parameter RING_WORDS, default 2048, SHALL set the ring length in 16-bit words (power of two, 2..2^24).
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL set the sample buffer depth (power of two, at least 4).
REQ-004 Clocking and reset SHALL be fixed as: one clock, M100CLK; reset is synchronous and active-high, port reset.
REQ-005 Ports SHALL be as follows, one per line:
  M100CLK  in  1  system clock
  reset  in  1  synchronous active-high reset
  start  in  1  one-cycle pulse that begins capture
  stop  in  1  one-cycle pulse that ends capture
  sample_valid  in  1  sample_data is valid this cycle
  sample_data  in  16  ADC sample
  Write_WaitRequest  in  1  Avalon slave stall
  Write_ChipEnable  out  1  Avalon chip select
  Write_Address  out  25  Avalon word address
  Write_ByteEnable  out  2  byte enables, active-high
  Write_WriteData  out  16  write data
  Write_Write  out  1  write request
  busy  out  1  state is not IDLE
  done  out  1  one-cycle pulse when drain completes
  overflow  out  1  sticky flag, a sample was dropped
  wrapped  out  1  sticky flag, the ring address wrapped
  words_written  out  25  count of completed writes since start
  drop_count  out  16  count of dropped samples

Function
REQ-006 The block SHALL have a state machine with states IDLE, RUN and DRAIN.
REQ-007 In IDLE, start SHALL move the block to RUN and, in the same edge, clear the FIFO, overflow, wrapped, words_written and drop_count, and set the address offset to 0.
REQ-008 In RUN, stop SHALL move the block to DRAIN; if start and stop are high in the same cycle, stop SHALL be ignored.
REQ-009 In DRAIN, once the FIFO is empty and no write is pending, the block SHALL return to IDLE and pulse done high for exactly one cycle.
REQ-010 Samples SHALL be pushed into the FIFO only in RUN; sample_valid in IDLE or DRAIN SHALL be ignored and SHALL NOT count as a drop.
REQ-011 A push SHALL be accepted if the FIFO is not full or a pop occurs in the same cycle; otherwise the sample SHALL be dropped, overflow set and drop_count incremented (saturating at 16'hFFFF).
REQ-012 Write_Write SHALL be asserted whenever the output register holds a word; Write_Address, Write_WriteData and Write_Write SHALL stay stable while Write_WaitRequest is high.
REQ-013 A transfer SHALL complete on a cycle with Write_Write=1 and Write_WaitRequest=0; on that edge the FIFO head (if any) SHALL load into the output register in the same cycle, giving back-to-back writes with no bubble.
REQ-014 Latency SHALL be as follows: a sample accepted at edge N into an empty FIFO, with no pending write, SHALL appear with Write_Write=1 at the output after edge N+1.
REQ-015 Write_Address SHALL equal ADDR_BASE + offset; offset SHALL increment per completed transfer and wrap from RING_WORDS-1 to 0, with wrapped set on the wrap.
REQ-016 words_written SHALL increment per completed transfer and wrap modulo 2^25.
REQ-017 Write_ByteEnable SHALL be 2'b11 and Write_ChipEnable SHALL be 1 at all times out of reset.
REQ-018 FIFO ordering SHALL be strict first-in, first-out; no sample SHALL be duplicated or reordered.

Reset
REQ-019 On reset the block SHALL enter IDLE and set Write_Write, busy, done, overflow and wrapped to 0; Write_Address to ADDR_BASE; Write_WriteData, words_written and drop_count to 0; and empty the FIFO.
REQ-020 A reset during a stalled transfer SHALL deassert Write_Write on the next edge regardless of Write_WaitRequest, and the word SHALL be discarded.

Configuration
REQ-021 With macro CAPTURE_DROP_COUNT_EN defined, drop_count SHALL operate as specified in REQ-011.
REQ-022 Without CAPTURE_DROP_COUNT_EN, drop_count SHALL be constant 0 with no counter logic, while overflow SHALL still operate.

Verification
REQ-023 Reset, start, then 8 samples 0x0001..0x0008 with Write_WaitRequest=0 SHALL produce 8 writes to addresses 0..7 with matching data; words_written SHALL be 8.
REQ-024 Holding Write_WaitRequest=1 for 10 cycles mid-stream SHALL keep address and data frozen; after release, samples SHALL complete in order with no loss if no more than 16 arrive.
REQ-025 With Write_WaitRequest=1, 20 consecutive samples SHALL accept 17 (16 in FIFO plus 1 in the output register), set overflow=1 and give drop_count=3 (0 without the macro).
REQ-026 With RING_WORDS=4, 6 samples SHALL be written to addresses 0,1,2,3,0,1 and set wrapped=1.
REQ-027 Stop with 5 words buffered SHALL flush all 5 writes, then pulse done for one cycle, then drop busy; sample_valid during DRAIN SHALL be ignored.
REQ-028 Reset asserted while Write_Write=1 and Write_WaitRequest=1 SHALL give Write_Write=0 and Write_Address=ADDR_BASE on the next edge.
